// File: rtl/mat_pkg.sv
// Shared constants and FSM state type for the 8x8 signed matrix-multiply family.
package mat_pkg;
    localparam int DIM    = 8;
    localparam int A_W    = 8;
    localparam int C_W    = 19;
    localparam int ADDR_W = 6;
    localparam int SUM_W  = C_W + 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/skid_fifo2.sv
// Two-entry synchronous FIFO; head is the oldest entry, count is 0..2.
module skid_fifo2 #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/mat_c_unloader.sv
// Streams the 64-entry C result RAM out on valid/ready, in row-major or storage
// order, and keeps a signed checksum of every word handed off.
module mat_c_unloader #(
    parameter int ROW_MAJOR = 1,
    parameter int C_W       = mat_pkg::C_W,
    parameter int ADDR_W    = mat_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [C_W-1:0]          rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [C_W-1:0]   out_data,
    output logic [ADDR_W-1:0]       out_idx,
    output logic                    out_last,
    output logic signed [C_W+5:0]   sum
);
    import mat_pkg::*;

    localparam int SW    = C_W + 6;
    localparam int H     = ADDR_W / 2;
    localparam int WORDS = 1 << ADDR_W;
    localparam int FW    = 1 + ADDR_W + C_W;

    state_t            state, state_nx;
    logic [ADDR_W:0]   k;
    logic              inflight;
    logic              inflight_last;
    logic [ADDR_W-1:0] inflight_addr;
    logic [1:0]        fcount;
    logic [FW-1:0]     fhead;
    logic [1:0]        occ;
    logic              pop;
    logic              start_ok;
    logic              reads_left;

    // Each FIFO entry carries its last flag and RAM address alongside the data.
    skid_fifo2 #(.W(FW)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data ({inflight_last, inflight_addr, rd_data}),
        .pop       (pop),
        .count     (fcount),
        .head      (fhead)
    );

    assign out_valid = (fcount != 2'd0);
    assign out_last  = fhead[FW-1];
    assign out_idx   = fhead[C_W +: ADDR_W];
    assign out_data  = fhead[C_W-1:0];
    assign pop       = out_valid && out_ready;

    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign start_ok   = (state == IDLE) && start;
    assign reads_left = !k[ADDR_W];

    // In-flight read counts toward occupancy so the FIFO can never overflow.
    assign occ   = fcount + {1'b0, inflight};
    assign rd_en = (state == RUN) && reads_left &&
                   ((occ <= 2'd1) || ((occ == 2'd2) && pop));

    // C[r][c] sits at 8*c + r, so row-major order swaps the two index halves.
    generate
        if (ROW_MAJOR != 0) begin : g_row
            assign rd_addr = {k[H-1:0], k[ADDR_W-1:H]};
        end else begin : g_col
            assign rd_addr = k[ADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (pop && out_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            k             <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            inflight_addr <= '0;
            sum           <= '0;
        end else begin
            state         <= state_nx;
            inflight      <= rd_en;
            inflight_addr <= rd_addr;
            inflight_last <= (k == (ADDR_W+1)'(WORDS - 1));
            if (start_ok)   k <= '0;
            else if (rd_en) k <= k + 1'b1;
            if (start_ok) sum <= '0;
            else if (pop) sum <= sum + SW'(out_data);
        end
    end
endmodule

// File: tb/tb_mat_c_unloader.sv
// Random-backpressure bench for mat_c_unloader: row-major and storage-order
// instances run in lockstep against a RAM model and a stream/sum reference.
module tb_mat_c_unloader;
    logic clk = 1'b0;
    logic reset, start, out_ready;
    always #5 clk = ~clk;

    logic signed [18:0] mem [64];

    logic               busy_r, done_r, rd_en_r, out_valid_r, out_last_r;
    logic [5:0]         rd_addr_r, out_idx_r;
    logic [18:0]        rd_data_r;
    logic signed [18:0] out_data_r;
    logic signed [24:0] sum_r;

    logic               busy_c, done_c, rd_en_c, out_valid_c, out_last_c;
    logic [5:0]         rd_addr_c, out_idx_c;
    logic [18:0]        rd_data_c;
    logic signed [18:0] out_data_c;
    logic signed [24:0] sum_c;

    mat_c_unloader #(.ROW_MAJOR(1), .C_W(19), .ADDR_W(6)) u_row (
        .clk(clk), .reset(reset), .start(start), .busy(busy_r), .done(done_r),
        .rd_en(rd_en_r), .rd_addr(rd_addr_r), .rd_data(rd_data_r),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
        .out_idx(out_idx_r), .out_last(out_last_r), .sum(sum_r)
    );

    mat_c_unloader #(.ROW_MAJOR(0), .C_W(19), .ADDR_W(6)) u_col (
        .clk(clk), .reset(reset), .start(start), .busy(busy_c), .done(done_c),
        .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .out_idx(out_idx_c), .out_last(out_last_c), .sum(sum_c)
    );

    // Synchronous C RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en_r) rd_data_r <= mem[rd_addr_r];
        if (rd_en_c) rd_data_c <= mem[rd_addr_c];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tg);
        chk({tg, "_busy_r"}, busy_r, 0);       chk({tg, "_busy_c"}, busy_c, 0);
        chk({tg, "_done_r"}, done_r, 0);       chk({tg, "_done_c"}, done_c, 0);
        chk({tg, "_rden_r"}, rd_en_r, 0);      chk({tg, "_rden_c"}, rd_en_c, 0);
        chk({tg, "_valid_r"}, out_valid_r, 0); chk({tg, "_valid_c"}, out_valid_c, 0);
        chk({tg, "_last_r"}, out_last_r, 0);   chk({tg, "_last_c"}, out_last_c, 0);
        chk({tg, "_addr_r"}, rd_addr_r, 0);    chk({tg, "_addr_c"}, rd_addr_c, 0);
        chk({tg, "_data_r"}, out_data_r, 0);   chk({tg, "_data_c"}, out_data_c, 0);
        chk({tg, "_idx_r"}, out_idx_r, 0);     chk({tg, "_idx_c"}, out_idx_c, 0);
        chk({tg, "_sum_r"}, sum_r, 0);         chk({tg, "_sum_c"}, sum_c, 0);
    endtask

    // One full start..done transfer. Word n of the row-major stream is C[n/8][n%8],
    // stored at 8*(n%8) + n/8; storage order is simply address n.
    task automatic run_stream(input int rdy_pct, input bit restart_mid, input bit do_reset);
        int t, n, stalls, ir, ic;
        longint msum;
        bit seen, stalled, any_done;
        logic signed [18:0] hd_r, hd_c;
        logic [5:0] hi_r, hi_c;
        t = 0; n = 0; stalls = 0; msum = 0; seen = 0; stalled = 0;
        hd_r = '0; hd_c = '0; hi_r = '0; hi_c = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_rise", busy_r, 1);
        chk("sum_clr_r", sum_r, 0);
        chk("sum_clr_c", sum_c, 0);
        while (!seen && t < 400) begin
            start = 1'b0;
            if (do_reset && n == 20) begin
                reset = 1'b0;
                #1;
                chk_idle("rst_mid");
                @(negedge clk); reset = 1'b1;
                any_done = 0;
                repeat (80) begin
                    @(negedge clk);
                    if (done_r || done_c) any_done = 1;
                end
                chk("rst_no_done", any_done, 0);
                chk("rst_sum", sum_r, 0);
                return;
            end
            if (done_r) begin
                seen = 1;
                chk("done_time", t, 66 + stalls);
                chk("done_c", done_c, 1);
                chk("word_count", n, 64);
                chk("sum_r", sum_r, msum);
                chk("sum_c", sum_c, msum);
            end else begin
                if (stalled) begin
                    chk("hold_valid", out_valid_r, 1);
                    chk("hold_d_r", out_data_r, hd_r);
                    chk("hold_i_r", out_idx_r, hi_r);
                    chk("hold_d_c", out_data_c, hd_c);
                    chk("hold_i_c", out_idx_c, hi_c);
                end
                out_ready = ($urandom_range(99) < rdy_pct);
                stalled = 0;
                if (out_valid_r) begin
                    if (out_ready) begin
                        ir = (n % 8) * 8 + n / 8;
                        ic = n;
                        chk("idx_r", out_idx_r, ir);
                        chk("data_r", out_data_r, mem[ir]);
                        chk("last_r", out_last_r, (n == 63) ? 1 : 0);
                        chk("idx_c", out_idx_c, ic);
                        chk("data_c", out_data_c, mem[ic]);
                        chk("last_c", out_last_c, (n == 63) ? 1 : 0);
                        msum += mem[ir];
                        n++;
                        if (restart_mid && n == 10) start = 1'b1;
                    end else begin
                        stalls++;
                        stalled = 1;
                        hd_r = out_data_r; hi_r = out_idx_r;
                        hd_c = out_data_c; hi_c = out_idx_c;
                    end
                end
                @(negedge clk);
                t++;
            end
        end
        chk("done_seen", seen, 1);
        @(negedge clk);
        chk("done_fall", done_r, 0);
        chk("busy_low", busy_r, 0);
        chk("sum_hold", sum_r, msum);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 19'(i - 32);
        @(negedge clk); @(negedge clk);
        chk_idle("reset");
        reset = 1'b1;

        run_stream(100, 0, 0);
        chk("sum_m32_r", sum_r, -32);
        chk("sum_m32_c", sum_c, -32);

        run_stream(55, 0, 0);
        run_stream(100, 1, 0);
        run_stream(70, 0, 0);

        for (int i = 0; i < 64; i++) mem[i] = 19'sd262143;
        run_stream(100, 0, 0);
        chk("sum_max", sum_r, 16777152);
        for (int i = 0; i < 64; i++) mem[i] = -19'sd262144;
        run_stream(80, 0, 0);
        chk("sum_min", sum_c, -16777216);

        for (int i = 0; i < 64; i++) mem[i] = 19'($urandom);
        run_stream(85, 0, 1);
        run_stream(75, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
